// File: rtl/axis_ethernet_tx_pad_fcs_pkg.sv
// EthernetBus: shared definitions for the Ethernet transmit path.
//   - CRC-32 polynomial (normal form) and initial value
//   - minimum Ethernet frame length without FCS
//   - transmit FSM state encoding
//   - helpers: bit reflection, byte count from a contiguous strobe
package EthernetBus;

  localparam logic [31:0] CRC32_POLY        = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT        = 32'hFFFFFFFF;
  localparam int          ETH_MIN_FRAME_LEN = 60;

  typedef logic [1:0] tx_state_t;
  localparam tx_state_t ST_DATA     = 2'd0; // also the idle state
  localparam tx_state_t ST_PAD      = 2'd1;
  localparam tx_state_t ST_FCS      = 2'd2;
  localparam tx_state_t ST_FCS_TAIL = 2'd3;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Strobes are contiguous from lane 0, so the highest set lane gives the count.
  function automatic logic [2:0] strb_bytes(input logic [3:0] s);
    logic [2:0] n;
    if (s[3])      n = 3'd4;
    else if (s[2]) n = 3'd3;
    else if (s[1]) n = 3'd2;
    else if (s[0]) n = 3'd1;
    else           n = 3'd0;
    return n;
  endfunction

endpackage

// File: rtl/axis_ethernet_tx_pad_fcs_if.sv
// AXIStream: 32-bit AXI4-Stream bundle including clock and reset.
//   receiver    : sink side (drives tready only)
//   transmitter : source side (drives clock/reset forward and all payload)
// Handshake: a beat transfers on a rising aclk edge where tvalid and tready
// are both 1; a source holding tvalid=1 keeps every payload signal stable
// until that transfer happens.
interface AXIStream;
  logic        aclk;
  logic        areset_n;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tid;
  logic        tdest;
  logic        twakeup;

  modport receiver (
    input  aclk, areset_n, tvalid, tdata, tstrb, tkeep, tlast,
           tuser, tid, tdest, twakeup,
    output tready
  );

  modport transmitter (
    output aclk, areset_n, tvalid, tdata, tstrb, tkeep, tlast,
           tuser, tid, tdest, twakeup,
    input  tready
  );
endinterface

// File: rtl/axis_ethernet_tx_pad_fcs_crc.sv
// EthernetCRC32_Update32: combinational reflected CRC-32 update over the
// lowest 0..4 bytes of a 32-bit word (byte 0 first, LSB first).
//   crc_in  : running CRC register value
//   data    : input word, byte k in data[8k+7:8k]
//   nbytes  : number of valid bytes (0..4); 0 passes crc_in through
//   crc_out : updated CRC register value (not complemented)
module EthernetCRC32_Update32
  import EthernetBus::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] crc_out
);
  localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nbytes) begin
        c = c ^ {24'd0, data[8*b +: 8]};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
      end
    end
    crc_out = c;
  end
endmodule

// File: rtl/axis_ethernet_tx_pad_fcs.sv
// axis_ethernet_tx_pad_fcs: pads Ethernet frames to MIN_LEN bytes with zeros
// and (APPEND_FCS=1) appends the CRC-32 FCS byte-packed after the last byte.
//   axi_rx  : input stream (receiver); its aclk/areset_n clock the block
//   axi_tx  : output stream (transmitter), fully registered
//   state_o : current FSM state (ST_DATA/ST_PAD/ST_FCS/ST_FCS_TAIL)
module axis_ethernet_tx_pad_fcs
  import EthernetBus::*;
#(
  parameter int MIN_LEN    = ETH_MIN_FRAME_LEN,
  parameter bit APPEND_FCS = 1'b1
) (
  AXIStream.receiver    axi_rx,
  AXIStream.transmitter axi_tx,
  output logic [1:0]    state_o
);
  localparam logic [11:0] MIN_L   = 12'(MIN_LEN);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  logic clk, rst_n;
  assign clk   = axi_rx.aclk;
  assign rst_n = axi_rx.areset_n;

  tx_state_t   state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d, crc_upd, fcs;
  logic [2:0]  fidx_q, fidx_d;
  logic        tvalid_q, tlast_q;
  logic [31:0] tdata_q;
  logic [3:0]  tstrb_q, tkeep_q;

  logic        out_free, rx_ready, step, ending, emit, pad_done, out_last;
  logic [2:0]  n, p, f, fidx, nbytes;
  logic [11:0] cnt_ext, cnt_pad, need;
  logic [31:0] word_in, out_data;
  logic [3:0]  out_strb;
  logic [1:0]  fsel;
  logic        unused_sigs;

  assign unused_sigs = ^{axi_rx.tkeep, axi_rx.tuser, axi_rx.tid, axi_rx.tdest, axi_rx.twakeup};

  // The output register can take a new word when empty or being drained.
  assign out_free = !tvalid_q || axi_tx.tready;
  assign rx_ready = rst_n && (state_q == ST_DATA) && out_free;

  // Source of this cycle's word: input data in ST_DATA, nothing otherwise.
  // Every non-DATA state is part of the frame ending.
  always_comb begin
    step    = 1'b0;
    ending  = 1'b1;
    n       = 3'd0;
    fidx    = 3'd0;
    word_in = '0;
    case (state_q)
      ST_DATA: begin
        step   = axi_rx.tvalid && rx_ready;
        ending = axi_rx.tlast;
        n      = strb_bytes(axi_rx.tstrb);
        for (int l = 0; l < 4; l++)
          if (3'(l) < n) word_in[8*l +: 8] = axi_rx.tdata[8*l +: 8];
      end
      ST_FCS_TAIL: begin
        step = out_free;
        fidx = fidx_q;
      end
      default: step = out_free;
    endcase
  end

  // Lane budget of the word: n data bytes, then p pad bytes (only while
  // ending and short of MIN_LEN), then f FCS bytes once padding is complete.
  always_comb begin
    cnt_ext = {1'b0, cnt_q} + {9'd0, n};
    need    = (cnt_ext < MIN_L) ? (MIN_L - cnt_ext) : 12'd0;
    p       = 3'd0;
    if (ending) p = (need < 12'(3'd4 - n)) ? need[2:0] : (3'd4 - n);
    cnt_pad  = cnt_ext + {9'd0, p};
    pad_done = (cnt_pad >= MIN_L);
    f = 3'd0;
    if (APPEND_FCS && ending && pad_done)
      f = ((3'd4 - fidx) < (3'd4 - n - p)) ? (3'd4 - fidx) : (3'd4 - n - p);
    nbytes   = n + p;
    out_last = ending && pad_done && (!APPEND_FCS || (fidx + f == 3'd4));
    // A strobe-less, non-last input beat is swallowed without output.
    emit     = step && (ending || n != 3'd0);
  end

  EthernetCRC32_Update32 u_crc (
    .crc_in  (crc_q),
    .data    (word_in),
    .nbytes  (nbytes),
    .crc_out (crc_upd)
  );

  // In FCS/FCS_TAIL nbytes is 0, so crc_upd is the stored final CRC.
  assign fcs = ~crc_upd;

  always_comb begin
    out_data = word_in;
    out_strb = '0;
    fsel     = 2'd0;
    for (int l = 0; l < 4; l++) begin
      if (3'(l) < n + p + f) out_strb[l] = 1'b1;
      if (3'(l) >= n + p && 3'(l) < n + p + f) begin
        fsel = 2'(fidx + 3'(l) - n - p);
        out_data[8*l +: 8] = fcs[8*fsel +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    fidx_d  = fidx_q;
    if (step) begin
      if (out_last) begin
        state_d = ST_DATA;
        cnt_d   = '0;
        crc_d   = CRC32_INIT;
        fidx_d  = '0;
      end else begin
        cnt_d = (cnt_pad > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_pad[10:0];
        crc_d = crc_upd;
        if (!ending)                           state_d = ST_DATA;
        else if (!pad_done)                    state_d = ST_PAD;
        else if (f == 3'd0 && fidx == 3'd0)   state_d = ST_FCS;
        else begin
          state_d = ST_FCS_TAIL;
          fidx_d  = fidx + f;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_DATA;
      cnt_q    <= '0;
      crc_q    <= CRC32_INIT;
      fidx_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tkeep_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      fidx_q  <= fidx_d;
      if (out_free) begin
        tvalid_q <= emit;
        if (emit) begin
          tdata_q <= out_data;
          tstrb_q <= out_strb;
          tlast_q <= out_last;
          tkeep_q <= 4'hF;
        end
      end
    end
  end

  assign axi_rx.tready   = rx_ready;
  assign axi_tx.aclk     = axi_rx.aclk;
  assign axi_tx.areset_n = axi_rx.areset_n;
  assign axi_tx.tvalid   = tvalid_q;
  assign axi_tx.tdata    = tdata_q;
  assign axi_tx.tstrb    = tstrb_q;
  assign axi_tx.tkeep    = tkeep_q;
  assign axi_tx.tlast    = tlast_q;
  assign axi_tx.tuser    = 1'b0;
  assign axi_tx.tid      = 1'b0;
  assign axi_tx.tdest    = 1'b0;
  assign axi_tx.twakeup  = 1'b1;
  assign state_o         = state_q;
endmodule

// File: tb/tb_axis_ethernet_tx_pad_fcs.sv
// Bench for axis_ethernet_tx_pad_fcs: directed frames (empty, short, exact,
// long, stalled, reset mid-frame) plus random frames, scored against a
// byte-level frame model.
module tb_axis_ethernet_tx_pad_fcs;
  localparam int MIN_LEN = 60;

  AXIStream rx_if();
  AXIStream tx_if();
  logic [1:0] state_dbg;

  axis_ethernet_tx_pad_fcs #(.MIN_LEN(MIN_LEN), .APPEND_FCS(1'b1)) dut (
    .axi_rx  (rx_if),
    .axi_tx  (tx_if),
    .state_o (state_dbg)
  );

  int          n_cmp;
  int          n_fail;
  int          rdy_mode;   // 0: always ready, 1: random, 2: toggle
  logic [36:0] exp_q[$];   // {tdata, tstrb, tlast}
  logic [7:0]  frame_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    rx_if.aclk = 1'b0;
    forever #5 rx_if.aclk = ~rx_if.aclk;
  end

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check_reset_state();
    check("rst_tvalid", 37'(tx_if.tvalid), 37'(0));
    check("rst_tlast",  37'(tx_if.tlast),  37'(0));
    check("rst_tdata",  37'(tx_if.tdata),  37'(0));
    check("rst_tstrb",  37'(tx_if.tstrb),  37'(0));
    check("rst_tkeep",  37'(tx_if.tkeep),  37'(0));
    check("rst_rx_tready", 37'(rx_if.tready), 37'(0));
    check("rst_state",  37'(state_dbg),    37'(0));
  endtask

  // ---------------- reference model ----------------
  // Frame bytes -> zero pad to MIN_LEN -> append ~CRC32 LSB byte first,
  // then slice the byte stream into 4-byte words.
  task automatic model_frame();
    logic [7:0]  ob[$];
    logic [31:0] c, w;
    logic [3:0]  s;
    ob = frame_q;
    while (ob.size() < MIN_LEN) ob.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (ob[i]) begin
      c = c ^ {24'd0, ob[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) ob.push_back(c[8*k +: 8]);
    for (int i = 0; i < ob.size(); i += 4) begin
      w = '0;
      s = '0;
      for (int b = 0; b < 4; b++)
        if (i + b < ob.size()) begin
          w[8*b +: 8] = ob[i+b];
          s[b] = 1'b1;
        end
      exp_q.push_back({w, s, (i + 4 >= ob.size())});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int   t;
    logic acc;
    rx_if.tvalid = 1'b1;
    rx_if.tdata  = d;
    rx_if.tstrb  = s;
    rx_if.tkeep  = 4'($urandom);
    rx_if.tlast  = l;
    t   = 0;
    acc = 1'b0;
    while (!acc && t < 2000) begin
      @(negedge rx_if.aclk);
      acc = rx_if.tready;
      @(posedge rx_if.aclk);
      #1;
      t++;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rx_accept_timeout: got no tready in %0d cycles want accept", t);
    end
  endtask

  task automatic send_frame(input int len, input bit zero_tail, input bit drops, input bit gaps);
    int          i, nb;
    logic        last;
    logic [31:0] d;
    frame_q.delete();
    for (int k = 0; k < len; k++) frame_q.push_back(8'($urandom));
    model_frame();
    i = 0;
    while (i < len) begin
      if (drops && $urandom_range(0, 5) == 0) send_beat($urandom, 4'b0000, 1'b0);
      nb   = (len - i > 4) ? 4 : len - i;
      last = (i + nb == len) && !zero_tail;
      d    = $urandom;
      for (int b = 0; b < nb; b++) d[8*b +: 8] = frame_q[i+b];
      send_beat(d, 4'((1 << nb) - 1), last);
      i += nb;
      if (gaps && $urandom_range(0, 3) == 0) begin
        rx_if.tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          @(posedge rx_if.aclk);
          #1;
        end
      end
    end
    if (zero_tail || len == 0) send_beat($urandom, 4'b0000, 1'b1);
    rx_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge rx_if.aclk);
      t++;
    end
    #1;
    check(name, 37'(exp_q.size()), 37'(0));
    exp_q.delete();
  endtask

  initial begin
    tx_if.tready = 1'b0;
    forever begin
      @(posedge rx_if.aclk);
      #1;
      case (rdy_mode)
        0:       tx_if.tready = 1'b1;
        1:       tx_if.tready = 1'($urandom_range(0, 1));
        default: tx_if.tready = ~tx_if.tready;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        stall_prev;
  logic [41:0] held;
  logic [36:0] exp_w;

  always @(negedge rx_if.aclk) begin
    if (!rx_if.areset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", 37'({tx_if.tvalid, tx_if.tdata, tx_if.tstrb}), 37'(held[41:5]));
      check("rx_tready_rule", 37'(rx_if.tready),
            37'((state_dbg == 2'd0) && (!tx_if.tvalid || tx_if.tready)));
      if (tx_if.tvalid && tx_if.tready) begin
        check("tkeep", 37'(tx_if.tkeep), 37'(4'hF));
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h want none", {tx_if.tdata, tx_if.tstrb, tx_if.tlast});
        end else begin
          exp_w = exp_q.pop_front();
          check("tx_beat", {tx_if.tdata, tx_if.tstrb, tx_if.tlast}, exp_w);
        end
      end
      stall_prev = tx_if.tvalid && !tx_if.tready;
      held = {tx_if.tvalid, tx_if.tdata, tx_if.tstrb, tx_if.tlast, tx_if.tkeep};
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    n_cmp    = 0;
    n_fail   = 0;
    rdy_mode = 0;
    stall_prev = 1'b0;
    rx_if.areset_n = 1'b0;
    rx_if.tvalid   = 1'b0;
    rx_if.tdata    = '0;
    rx_if.tstrb    = '0;
    rx_if.tkeep    = '0;
    rx_if.tlast    = 1'b0;
    rx_if.tuser    = 1'b0;
    rx_if.tid      = 1'b0;
    rx_if.tdest    = 1'b0;
    rx_if.twakeup  = 1'b0;
    repeat (3) @(posedge rx_if.aclk);
    @(negedge rx_if.aclk);
    check_reset_state();
    @(posedge rx_if.aclk);
    #1;
    rx_if.areset_n = 1'b1;

    // empty frame, short, short-with-fcs-split, exact, long
    send_frame(0, 1'b0, 1'b0, 1'b0);   wait_drain("drain_empty");
    send_frame(42, 1'b0, 1'b0, 1'b0);  wait_drain("drain_42");
    send_frame(61, 1'b0, 1'b0, 1'b0);  wait_drain("drain_61");
    send_frame(60, 1'b0, 1'b0, 1'b0);  wait_drain("drain_60");
    send_frame(57, 1'b0, 1'b0, 1'b0);  wait_drain("drain_57");
    send_frame(100, 1'b1, 1'b1, 1'b0); wait_drain("drain_100_ztail");
    // back-to-back frames with no idle between them
    send_frame(63, 1'b0, 1'b0, 1'b0);
    send_frame(5, 1'b0, 1'b0, 1'b0);   wait_drain("drain_b2b");

    rdy_mode = 2;
    send_frame(64, 1'b0, 1'b0, 1'b0);  wait_drain("drain_64_toggle");
    rdy_mode = 0;

    // reset after word 5 of a 100-byte frame
    for (int k = 0; k < 5; k++) begin
      d = $urandom;
      exp_q.push_back({d, 4'hF, 1'b0});
      send_beat(d, 4'hF, 1'b0);
    end
    rx_if.tvalid = 1'b0;
    repeat (3) @(posedge rx_if.aclk);
    #1;
    check("pre_reset_drain", 37'(exp_q.size()), 37'(0));
    rx_if.areset_n = 1'b0;
    repeat (2) @(posedge rx_if.aclk);
    @(negedge rx_if.aclk);
    check_reset_state();
    @(posedge rx_if.aclk);
    #1;
    rx_if.areset_n = 1'b1;
    send_frame(60, 1'b0, 1'b0, 1'b0);  wait_drain("drain_after_reset");

    // random frames, random backpressure, gaps and dropped beats
    rdy_mode = 1;
    for (int fr = 0; fr < 25; fr++) begin
      int len;
      bit zt;
      len = $urandom_range(0, 130);
      zt  = (len % 4 == 0) && ($urandom_range(0, 1) == 1);
      send_frame(len, zt, 1'b1, 1'b1);
    end
    wait_drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
